// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - data memory request/grant/response bus
// Purpose: bundles the data-memory handshake between lsu_mem_stage and memory.
// Signals:
//   dmem_req    request, high for the whole REQ phase
//   dmem_we     1 = write
//   dmem_addr   word-aligned address
//   dmem_be     byte enables
//   dmem_wdata  lane-replicated store data
//   dmem_gnt    request accepted this cycle
//   dmem_rvalid read data valid (no earlier than the cycle after gnt)
//   dmem_rdata  read word
// Modports: master (LSU side), slave (memory side).
interface lsu_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - memory stage with load/store handshake and error reporting
// Purpose: passes non-memory results to the register file in one cycle; runs
// loads/stores against data memory with alignment, extension, stall and errors.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   ex_*               instruction from execute, sampled only when idle
//   stall_o            upstream hold, high whenever an access is outstanding
//   rd_addr/data/wen   register file write port, rd_wen pulses once
//   err_o, err_cause   one-cycle error pulse; 01 misaligned, 10 timeout, 11 illegal
//   dmem               data memory bus (master side)
module lsu_mem_stage #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_wen,
  input  logic [31:0] ex_rd_data,
  output logic        stall_o,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_wen,
  output logic        err_o,
  output logic [1:0]  err_cause,
  lsu_mem_stage_if.master dmem
);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Captured operation
  logic        op_store, op_store_nxt;
  logic [2:0]  op_f3, op_f3_nxt;
  logic [1:0]  op_off, op_off_nxt;
  logic [4:0]  op_rd, op_rd_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [3:0]  be_q, be_nxt;
  logic [31:0] wdata_q, wdata_nxt;

  // Output registers
  logic [4:0]  rd_addr_nxt;
  logic [31:0] rd_data_nxt;
  logic        rd_wen_nxt;
  logic        err_nxt;
  logic [1:0]  cause_nxt;

  // Decode of the incoming instruction
  logic        is_mem;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Load extraction
  logic [31:0] lane;
  logic [31:0] load_val;
  logic        timeout;

  always_comb begin
    is_mem  = ex_is_load | ex_is_store;
    illegal = 1'b0;
    if (ex_is_load && ex_is_store) begin
      illegal = 1'b1;
    end else if (ex_is_load) begin
      illegal = !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (ex_is_store) begin
      illegal = !(ex_funct3 inside {3'b000, 3'b001, 3'b010});
    end
    // funct3[1:0] carries the size for both signed and unsigned loads
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
  end

  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << ex_addr[1:0];
        wdata_calc = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << ex_addr[1:0];
        wdata_calc = {2{ex_store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = ex_store_data;
      end
    endcase
  end

  always_comb begin
    lane = dmem.dmem_rdata >> {op_off, 3'b000};
    case (op_f3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // The counter runs across REQ and WAIT, so the budget covers gnt and rvalid together
  assign timeout = (cnt >= CNT_W'(MAX_WAIT - 1));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    op_store_nxt = op_store;
    op_f3_nxt    = op_f3;
    op_off_nxt   = op_off;
    op_rd_nxt    = op_rd;
    addr_nxt     = addr_q;
    be_nxt       = be_q;
    wdata_nxt    = wdata_q;
    rd_addr_nxt  = rd_addr;
    rd_data_nxt  = rd_data;
    rd_wen_nxt   = 1'b0;
    err_nxt      = 1'b0;
    cause_nxt    = 2'b00;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            rd_addr_nxt = ex_rd_addr;
            rd_data_nxt = ex_rd_data;
            rd_wen_nxt  = ex_rd_wen && (ex_rd_addr != 5'd0);
          end else if (illegal) begin
            err_nxt   = 1'b1;
            cause_nxt = CAUSE_ILLEGAL;
          end else if (misaligned) begin
            err_nxt   = 1'b1;
            cause_nxt = CAUSE_MISALIGN;
          end else begin
            state_nxt    = REQ;
            cnt_nxt      = '0;
            op_store_nxt = ex_is_store;
            op_f3_nxt    = ex_funct3;
            op_off_nxt   = ex_addr[1:0];
            op_rd_nxt    = ex_rd_addr;
            addr_nxt     = {ex_addr[31:2], 2'b00};
            be_nxt       = be_calc;
            wdata_nxt    = wdata_calc;
          end
        end
      end

      REQ: begin
        // rvalid is not looked at here: it cannot belong to this request yet
        if (dmem.dmem_gnt) begin
          state_nxt = op_store ? IDLE : WAIT;
          cnt_nxt   = cnt + CNT_W'(1);
        end else if (timeout) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_nxt   = IDLE;
          rd_addr_nxt = op_rd;
          rd_data_nxt = load_val;
          rd_wen_nxt  = (op_rd != 5'd0);
        end else if (timeout) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_store  <= 1'b0;
      op_f3     <= 3'd0;
      op_off    <= 2'd0;
      op_rd     <= 5'd0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      rd_addr   <= 5'd0;
      rd_data   <= 32'd0;
      rd_wen    <= 1'b0;
      err_o     <= 1'b0;
      err_cause <= 2'b00;
    end else begin
      cnt       <= cnt_nxt;
      op_store  <= op_store_nxt;
      op_f3     <= op_f3_nxt;
      op_off    <= op_off_nxt;
      op_rd     <= op_rd_nxt;
      addr_q    <= addr_nxt;
      be_q      <= be_nxt;
      wdata_q   <= wdata_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_data   <= rd_data_nxt;
      rd_wen    <= rd_wen_nxt;
      err_o     <= err_nxt;
      err_cause <= cause_nxt;
    end
  end

  // Decoded from the state register only, so reset drops req/stall immediately
  assign stall_o         = (state != IDLE);
  assign dmem.dmem_req   = (state == REQ);
  assign dmem.dmem_we    = (state == REQ) && op_store;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data, ex_rd_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
  logic        stall_o, rd_wen, err_o;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  err_cause;

  lsu_mem_stage_if mif();

  lsu_mem_stage #(.MAX_WAIT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_rd_data(ex_rd_data),
    .stall_o(stall_o), .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen(rd_wen),
    .err_o(err_o), .err_cause(err_cause),
    .dmem(mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdv, mem;
    logic [4:0]  rd;
    logic        wen;
    logic        e_err;
    logic [1:0]  e_cause;
    logic        e_rd_wen;
    logic [31:0] e_rd_data, e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] sdata, logic [31:0] rdv, logic [31:0] mem,
                              logic [4:0] rd, logic wen, logic e_err, logic [1:0] e_cause,
                              logic e_rd_wen, logic [31:0] e_rd_data, logic [31:0] e_addr,
                              logic [3:0] e_be, logic [31:0] e_wdata);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdv = rdv;
    v.mem = mem; v.rd = rd; v.wen = wen; v.e_err = e_err; v.e_cause = e_cause;
    v.e_rd_wen = e_rd_wen; v.e_rd_data = e_rd_data; v.e_addr = e_addr;
    v.e_be = e_be; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for exactly one accepting edge
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input logic wen, input logic [31:0] rdv);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_store_data = sd; ex_rd_addr = rd; ex_rd_wen = wen; ex_rd_data = rdv;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_funct3 = 0;
    ex_addr = 0; ex_store_data = 0; ex_rd_addr = 0; ex_rd_wen = 0; ex_rd_data = 0;
    mif.dmem_gnt = 0; mif.dmem_rvalid = 0; mif.dmem_rdata = 0;

    //        ld st f3      addr        sdata         rdv        mem           rd wen err cause wen rd_data       addr        be       wdata
    vecs[0]  = mk(0, 0, 3'b000, 32'h0,   32'h0,        32'h1234, 32'h0,        5, 1, 0, 2'b00, 1, 32'h1234,     32'h0,   4'h0,    32'h0);
    vecs[1]  = mk(0, 0, 3'b000, 32'h0,   32'h0,        32'h5555, 32'h0,        0, 1, 0, 2'b00, 0, 32'h5555,     32'h0,   4'h0,    32'h0);
    vecs[2]  = mk(0, 0, 3'b000, 32'h0,   32'h0,        32'hDEAD, 32'h0,        7, 0, 0, 2'b00, 0, 32'hDEAD,     32'h0,   4'h0,    32'h0);
    vecs[3]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h0,    32'h80FF7F01, 3, 1, 0, 2'b00, 1, 32'hFFFFFF80, 32'h100, 4'h0,    32'h0);
    vecs[4]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h0,    32'h80FF7F01, 4, 1, 0, 2'b00, 1, 32'h00000080, 32'h100, 4'h0,    32'h0);
    vecs[5]  = mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h0,    32'h80FF7F01, 6, 1, 0, 2'b00, 1, 32'hFFFF80FF, 32'h100, 4'h0,    32'h0);
    vecs[6]  = mk(1, 0, 3'b101, 32'h100, 32'h0,        32'h0,    32'h80FF7F01, 8, 1, 0, 2'b00, 1, 32'h00007F01, 32'h100, 4'h0,    32'h0);
    vecs[7]  = mk(1, 0, 3'b010, 32'h40,  32'h0,        32'h0,    32'hCAFEBABE, 9, 1, 0, 2'b00, 1, 32'hCAFEBABE, 32'h40,  4'h0,    32'h0);
    vecs[8]  = mk(1, 0, 3'b010, 32'h44,  32'h0,        32'h0,    32'h11223344, 0, 1, 0, 2'b00, 0, 32'h11223344, 32'h44,  4'h0,    32'h0);
    vecs[9]  = mk(0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0,    32'h0,        1, 1, 0, 2'b00, 0, 32'h0,        32'h300, 4'b0010, 32'hA5A5A5A5);
    vecs[10] = mk(0, 1, 3'b010, 32'h308, 32'hDEADBEEF, 32'h0,    32'h0,        2, 1, 0, 2'b00, 0, 32'h0,        32'h308, 4'b1111, 32'hDEADBEEF);
    vecs[11] = mk(0, 1, 3'b001, 32'h200, 32'hFFFF1234, 32'h0,    32'h0,        2, 1, 0, 2'b00, 0, 32'h0,        32'h200, 4'b0011, 32'h12341234);
    vecs[12] = mk(1, 0, 3'b010, 32'h6,   32'h0,        32'h0,    32'h0,        3, 1, 1, 2'b01, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[13] = mk(1, 0, 3'b011, 32'h0,   32'h0,        32'h0,    32'h0,        3, 1, 1, 2'b11, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[14] = mk(1, 0, 3'b001, 32'h101, 32'h0,        32'h0,    32'h0,        3, 1, 1, 2'b01, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[15] = mk(0, 1, 3'b100, 32'h0,   32'h0,        32'h0,    32'h0,        3, 1, 1, 2'b11, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[16] = mk(1, 1, 3'b010, 32'h0,   32'h0,        32'h0,    32'h0,        3, 1, 1, 2'b11, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[17] = mk(1, 0, 3'b110, 32'h0,   32'h0,        32'h0,    32'h0,        3, 1, 1, 2'b11, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[18] = mk(0, 1, 3'b010, 32'h302, 32'h1,        32'h0,    32'h0,        3, 1, 1, 2'b01, 0, 32'h0,        32'h0,   4'h0,    32'h0);
    vecs[19] = mk(0, 1, 3'b001, 32'h303, 32'h1,        32'h0,    32'h0,        3, 1, 1, 2'b01, 0, 32'h0,        32'h0,   4'h0,    32'h0);

    // Reset values, asynchronous: no clock edge has occurred yet
    #1;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_rd_wen", 32'(rd_wen), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_req", 32'(mif.dmem_req), 0);
    chk("rst_we", 32'(mif.dmem_we), 0);
    chk("rst_addr", mif.dmem_addr, 0);
    chk("rst_be", 32'(mif.dmem_be), 0);
    chk("rst_wdata", mif.dmem_wdata, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_cause", 32'(err_cause), 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v = vecs[i];
      issue(v.ld, v.st, v.f3, v.addr, v.sdata, v.rd, v.wen, v.rdv);
      if (!v.ld && !v.st) begin
        chk($sformatf("v%0d_rd_wen", i), 32'(rd_wen), 32'(v.e_rd_wen));
        chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(v.rd));
        chk($sformatf("v%0d_rd_data", i), rd_data, v.e_rd_data);
        chk($sformatf("v%0d_stall", i), 32'(stall_o), 0);
        chk($sformatf("v%0d_err", i), 32'(err_o), 0);
      end else if (v.e_err) begin
        chk($sformatf("v%0d_err", i), 32'(err_o), 1);
        chk($sformatf("v%0d_cause", i), 32'(err_cause), 32'(v.e_cause));
        chk($sformatf("v%0d_req", i), 32'(mif.dmem_req), 0);
        chk($sformatf("v%0d_stall", i), 32'(stall_o), 0);
        chk($sformatf("v%0d_rd_wen", i), 32'(rd_wen), 0);
        tick();
        chk($sformatf("v%0d_err_pulse", i), 32'(err_o), 0);
        chk($sformatf("v%0d_cause_clr", i), 32'(err_cause), 0);
      end else begin
        chk($sformatf("v%0d_stall", i), 32'(stall_o), 1);
        chk($sformatf("v%0d_req", i), 32'(mif.dmem_req), 1);
        chk($sformatf("v%0d_addr", i), mif.dmem_addr, v.e_addr);
        chk($sformatf("v%0d_we", i), 32'(mif.dmem_we), 32'(v.st));
        if (v.st) begin
          chk($sformatf("v%0d_be", i), 32'(mif.dmem_be), 32'(v.e_be));
          chk($sformatf("v%0d_wdata", i), mif.dmem_wdata, v.e_wdata);
        end
        mif.dmem_gnt = 1'b1;
        tick();
        mif.dmem_gnt = 1'b0;
        chk($sformatf("v%0d_req_drop", i), 32'(mif.dmem_req), 0);
        if (v.st) begin
          chk($sformatf("v%0d_stall_done", i), 32'(stall_o), 0);
          chk($sformatf("v%0d_no_wb", i), 32'(rd_wen), 0);
        end else begin
          chk($sformatf("v%0d_stall_wait", i), 32'(stall_o), 1);
          mif.dmem_rvalid = 1'b1;
          mif.dmem_rdata = v.mem;
          tick();
          mif.dmem_rvalid = 1'b0;
          chk($sformatf("v%0d_rd_wen", i), 32'(rd_wen), 32'(v.e_rd_wen));
          chk($sformatf("v%0d_rd_data", i), rd_data, v.e_rd_data);
          chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(v.rd));
          chk($sformatf("v%0d_stall_done", i), 32'(stall_o), 0);
          tick();
          chk($sformatf("v%0d_wen_pulse", i), 32'(rd_wen), 0);
        end
      end
      tick();
    end

    // SH at 0x202 with gnt arriving in the third REQ cycle
    issue(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 5'd4, 1'b1, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sh_req_c%0d", c), 32'(mif.dmem_req), 1);
      chk($sformatf("sh_stall_c%0d", c), 32'(stall_o), 1);
      chk($sformatf("sh_we_c%0d", c), 32'(mif.dmem_we), 1);
      chk($sformatf("sh_be_c%0d", c), 32'(mif.dmem_be), 32'hC);
      chk($sformatf("sh_wdata_c%0d", c), mif.dmem_wdata, 32'hABCDABCD);
      chk($sformatf("sh_addr_c%0d", c), mif.dmem_addr, 32'h200);
      if (c == 2) mif.dmem_gnt = 1'b1;
      tick();
    end
    mif.dmem_gnt = 1'b0;
    chk("sh_req_drop", 32'(mif.dmem_req), 0);
    chk("sh_stall_drop", 32'(stall_o), 0);
    chk("sh_no_wb", 32'(rd_wen), 0);
    chk("sh_no_err", 32'(err_o), 0);
    tick();

    // rvalid together with gnt is ignored; the following rvalid completes
    issue(1, 0, 3'b010, 32'h50, 32'h0, 5'd13, 1'b1, 32'h0);
    mif.dmem_gnt = 1'b1; mif.dmem_rvalid = 1'b1; mif.dmem_rdata = 32'h99999999;
    tick();
    mif.dmem_gnt = 1'b0; mif.dmem_rvalid = 1'b0;
    chk("gv_no_wb", 32'(rd_wen), 0);
    chk("gv_stall", 32'(stall_o), 1);
    mif.dmem_rvalid = 1'b1; mif.dmem_rdata = 32'h13572468;
    tick();
    mif.dmem_rvalid = 1'b0;
    chk("gv_rd_wen", 32'(rd_wen), 1);
    chk("gv_rd_data", rd_data, 32'h13572468);
    tick();

    // Timeout: LW granted at once, rvalid never comes; error four cycles after REQ entry
    issue(1, 0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b1, 32'h0);
    chk("to_req", 32'(mif.dmem_req), 1);
    mif.dmem_gnt = 1'b1;
    tick();
    mif.dmem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("to_wait_stall_c%0d", c), 32'(stall_o), 1);
      chk($sformatf("to_wait_err_c%0d", c), 32'(err_o), 0);
      tick();
    end
    chk("to_err", 32'(err_o), 1);
    chk("to_cause", 32'(err_cause), 32'h2);
    chk("to_stall", 32'(stall_o), 0);
    chk("to_req_drop", 32'(mif.dmem_req), 0);
    chk("to_no_wb", 32'(rd_wen), 0);
    mif.dmem_rvalid = 1'b1; mif.dmem_rdata = 32'hFFFFFFFF;
    tick();
    mif.dmem_rvalid = 1'b0;
    chk("to_late_rvalid_wb", 32'(rd_wen), 0);
    chk("to_err_pulse", 32'(err_o), 0);
    chk("to_late_stall", 32'(stall_o), 0);
    tick();

    // Completion in the same cycle as the timeout limit wins
    issue(1, 0, 3'b010, 32'h20, 32'h0, 5'd12, 1'b1, 32'h0);
    mif.dmem_gnt = 1'b1;
    tick();
    mif.dmem_gnt = 1'b0;
    tick(); tick();
    mif.dmem_rvalid = 1'b1; mif.dmem_rdata = 32'h0BADF00D;
    tick();
    mif.dmem_rvalid = 1'b0;
    chk("race_rd_wen", 32'(rd_wen), 1);
    chk("race_rd_data", rd_data, 32'h0BADF00D);
    chk("race_no_err", 32'(err_o), 0);
    tick();

    // Reset while in WAIT
    issue(1, 0, 3'b010, 32'h24, 32'h0, 5'd11, 1'b1, 32'h0);
    mif.dmem_gnt = 1'b1;
    tick();
    mif.dmem_gnt = 1'b0;
    chk("rw_stall_pre", 32'(stall_o), 1);
    #2 rst = 1'b0;
    #1;
    chk("rw_stall", 32'(stall_o), 0);
    chk("rw_req", 32'(mif.dmem_req), 0);
    chk("rw_rd_wen", 32'(rd_wen), 0);
    chk("rw_addr", mif.dmem_addr, 0);
    mif.dmem_rvalid = 1'b1; mif.dmem_rdata = 32'h77777777;
    tick();
    rst = 1'b1;
    tick();
    mif.dmem_rvalid = 1'b0;
    chk("rw_late_rvalid_wb", 32'(rd_wen), 0);
    chk("rw_late_stall", 32'(stall_o), 0);
    issue(0, 0, 3'b000, 32'h0, 32'h0, 5'd10, 1'b1, 32'h00000ABC);
    chk("rw_after_wen", 32'(rd_wen), 1);
    chk("rw_after_addr", 32'(rd_addr), 32'd10);
    chk("rw_after_data", rd_data, 32'h00000ABC);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
